// File: rtl/demux12_stream.sv
// 1:2 stream demux: each channel has a 2-entry FIFO, so a word is visible one cycle after its push.
// inp_ready depends only on the selected channel. Macro DEMUX12_STREAM_COUNT_EN builds the delivered-word counters.
module demux12_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o,
  output logic             full_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Vacated slots are cleared so the head reads as zero when the channel is empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          state_d = ONE;
          head_d  = din_i;
        end
      end
      ONE: begin
        if (push_i && pop_i) begin
          head_d = din_i;
        end else if (push_i) begin
          state_d = FULL;
          tail_d  = din_i;
        end else if (pop_i) begin
          state_d = EMPTY;
          head_d  = '0;
        end
      end
      FULL: begin
        if (pop_i) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  assign dout_o = head_q;
  assign vld_o  = (state_q != EMPTY);
  assign full_o = (state_q == FULL);
endmodule

module demux12_stream #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp_data,
  input  logic             inp_valid,
  input  logic             sel,
  output logic             inp_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);
  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;

  assign inp_ready = !rst && (sel ? !full1 : !full0);
  assign push0     = inp_valid && inp_ready && !sel;
  assign push1     = inp_valid && inp_ready && sel;
  assign pop0      = out0_valid && out0_ready;
  assign pop1      = out1_valid && out1_ready;

  demux12_fifo2 #(.WIDTH(WIDTH)) u_ch0 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push0),
    .pop_i  (pop0),
    .din_i  (inp_data),
    .dout_o (out0_data),
    .vld_o  (out0_valid),
    .full_o (full0)
  );

  demux12_fifo2 #(.WIDTH(WIDTH)) u_ch1 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push1),
    .pop_i  (pop1),
    .din_i  (inp_data),
    .dout_o (out1_data),
    .vld_o  (out1_valid),
    .full_o (full1)
  );

`ifdef DEMUX12_STREAM_COUNT_EN
  logic [CNTW-1:0] cnt0_q, cnt0_d;
  logic [CNTW-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = pop0 ? cnt0_q + CNTW'(1) : cnt0_q;
    cnt1_d = pop1 ? cnt1_q + CNTW'(1) : cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule

// File: doc/demux12_stream.md
DEMUX12_STREAM -- requirements
Module: demux12_stream

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (legal 1..32).
REQ-002 Parameter: CNTW, 16, delivered-word counter width in bits.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: inp_data  input  WIDTH  word offered by the upstream source.
REQ-007 Port: inp_valid  input  1  inp_data and sel are valid this cycle.
REQ-008 Port: sel  input  1  destination of the offered word: 0 routes to out0, 1 routes to out1.
REQ-009 Port: inp_ready  output  1  the offered word is accepted this cycle.
REQ-010 Port: out0_data / out1_data  output  WIDTH  head word of channel 0 / channel 1.
REQ-011 Port: out0_valid / out1_valid  output  1  channel holds at least one word.
REQ-012 Port: out0_ready / out1_ready  input  1  downstream consumer takes the head word.
REQ-013 Port: cnt0 / cnt1  output  CNTW  words delivered on channel 0 / channel 1.

Function
REQ-014 Each channel has a 2-entry FIFO, with an occupancy state of EMPTY(0), ONE(1) or FULL(2).
REQ-015 inp_ready is combinational and equals NOT FULL for the channel selected by sel, so it is independent of inp_valid; it is 0 while rst=1.
REQ-016 A push occurs when inp_valid=1 and inp_ready=1; the word enters the tail of FIFO[sel] and the other channel is unaffected.
REQ-017 A pop occurs on channel N when outN_valid=1 and outN_ready=1; the head entry is removed.
REQ-018 Latency: a word pushed at edge k is visible on outN_data with outN_valid=1 after edge k; there is no same-cycle bypass.
REQ-019 outN_valid=1 exactly when the channel is in ONE or FULL; outN_data is the head entry when valid and all-zero when EMPTY.
REQ-020 Words leave each channel in arrival order; there is no ordering relation between the two channels.
REQ-021 Channel transitions:
  - EMPTY with push: goes to ONE.
  - ONE with push only: goes to FULL.
  - ONE with pop only: goes to EMPTY.
  - ONE with push and pop: stays ONE, and the new word becomes the head.
  - FULL with pop: goes to ONE.
  - FULL with push: impossible, because inp_ready=0.
REQ-022 A push to one channel and a pop from the other in the same cycle are both honoured.
REQ-023 Back-pressure on one channel does not block traffic to the other channel: when sel changes, inp_ready follows the newly selected channel's occupancy.
REQ-024 While inp_valid=1 and inp_ready=0, the upstream source holds inp_data and sel stable (source obligation); the block does not check this.
REQ-025 outN_data and outN_valid remain stable while outN_valid=1 and outN_ready=0.

Reset
REQ-026 When rst=1 at a rising edge, both channels go to EMPTY, all storage is zeroed, and cnt0=cnt1=0.
REQ-027 Reset values: outN_valid=0, outN_data=0, cnt0=cnt1=0, and inp_ready=0 while rst=1.
REQ-028 Reset asserted mid-operation discards all buffered words; a push or pop presented in a cycle with rst=1 has no effect.
REQ-029 In the first cycle after rst falls, inp_ready=1 for either value of sel.

Configuration
REQ-030 Macro DEMUX12_STREAM_COUNT_EN enables the delivered-word counters.
REQ-031 With the macro defined, cntN increments by 1 on each pop of channel N and wraps from all-ones to 0.
REQ-032 Without the macro, the cnt0 and cnt1 ports still exist but are tied to 0, and no counter registers are built.

Verification (WIDTH=8, CNTW=16, macro defined unless stated)
REQ-033 Basic routing:
  - Stimulus: push 0xA5 with sel=0, then 0x3C with sel=1, with both outN_ready=1.
  - Response: out0 shows 0xA5 for 1 cycle, out1 shows 0x3C for 1 cycle, and cnt0=1, cnt1=1.
REQ-034 Full and back-pressure:
  - Stimulus: out0_ready=0; offer 0x01, 0x02 and 0x03 with sel=0.
  - Response: inp_ready drops after 2 pushes, and 0x03 is held.
  - Follow-on stimulus: raise out0_ready.
  - Follow-on response: 0x01, 0x02 and 0x03 are delivered in order.
REQ-035 Channel independence:
  - Stimulus: channel 0 full with out0_ready=0; offer 0x77 with sel=1.
  - Response: inp_ready=1, 0x77 is accepted and appears on out1 the next cycle.
REQ-036 Simultaneous push and pop in ONE:
  - Stimulus: channel 1 holds 0x10; push 0x20 (sel=1) and pop in the same cycle.
  - Response: out1_valid stays 1, out1_data becomes 0x20, and cnt1 increments by 1.
REQ-037 Reset mid-operation:
  - Stimulus: both channels FULL, then assert rst for 1 cycle.
  - Response: after the edge, out0_valid=0, out1_valid=0, cnt0=0, cnt1=0, and inp_ready=1 once rst=0.
REQ-038 Counter wrap and compiled-out behaviour:
  - Stimulus: preload cnt0 to 0xFFFF by 65535 pops, then pop once more.
  - Response: cnt0=0x0000.
  - Stimulus: rebuild without the macro and repeat REQ-033.
  - Response: cnt0=cnt1=0 throughout, and data behaviour is identical to REQ-033.
